// File: rtl/multiply_constant_shift_add_seq.sv
// Sequential constant multiplier: mul = ext(a) * CONST.
// One shift-and-add step is performed per clock, with valid/ready on both sides.
// Every bit of CONST costs exactly one CALC cycle, so latency is fixed.
module multiply_constant_shift_add_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CONST_WIDTH = 8,
  parameter int unsigned CONST       = 17,
  parameter bit          SIGNED      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+CONST_WIDTH-1:0] mul
);

  localparam int unsigned OUT_W = WIDTH + CONST_WIDTH;
  localparam int unsigned IDX_W = (CONST_WIDTH > 1) ? $clog2(CONST_WIDTH) : 1;
  localparam logic [CONST_WIDTH-1:0] CONST_V = CONST_WIDTH'(CONST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CONST_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   op_sh_q, op_sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   mul_q, mul_d;
  logic [OUT_W-1:0]   a_ext;
  logic [OUT_W-1:0]   sum;

  // Operand widened to the product width, zero- or sign-extended.
  assign a_ext = SIGNED ? {{CONST_WIDTH{a[WIDTH-1]}}, a}
                        : {{CONST_WIDTH{1'b0}}, a};

  // The single adder: add the shifted operand when the current constant bit is set.
  assign sum = acc_q + (CONST_V[idx_q] ? op_sh_q : '0);

  // Handshake flags depend only on the current state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign mul       = mul_q;

  // Next-state and datapath update for the accept / shift-add / present sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_sh_d = op_sh_q;
    idx_d   = idx_q;
    mul_d   = mul_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_sh_d = a_ext;
          acc_d   = '0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = sum;
        op_sh_d = op_sh_q << 1;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          mul_d   = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_sh_q <= '0;
      idx_q   <= '0;
      mul_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_sh_q <= op_sh_d;
      idx_q   <= idx_d;
      mul_q   <= mul_d;
    end
  end

endmodule

// File: tb/tb_multiply_constant_shift_add_seq.sv
// Directed bench for multiply_constant_shift_add_seq with four parameterisations:
// defaults, signed operand, a 12x5 sweep with CONST=31, and CONST=0.
module tb_multiply_constant_shift_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] a;
  int          sel;

  logic        in_valid0, in_valid1, in_valid2, in_valid3;
  logic        out_ready0, out_ready1, out_ready2, out_ready3;
  logic        in_ready0, in_ready1, in_ready2, in_ready3;
  logic        out_valid0, out_valid1, out_valid2, out_valid3;
  logic [15:0] mul0, mul1, mul3;
  logic [16:0] mul2;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [31:0] obs_mul;

  int checks;
  int errors;

  multiply_constant_shift_add_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a[7:0]),
    .out_valid(out_valid0), .out_ready(out_ready0), .mul(mul0)
  );

  multiply_constant_shift_add_seq #(.WIDTH(8), .CONST_WIDTH(8), .CONST(17), .SIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a[7:0]),
    .out_valid(out_valid1), .out_ready(out_ready1), .mul(mul1)
  );

  multiply_constant_shift_add_seq #(.WIDTH(12), .CONST_WIDTH(5), .CONST(31), .SIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a),
    .out_valid(out_valid2), .out_ready(out_ready2), .mul(mul2)
  );

  multiply_constant_shift_add_seq #(.WIDTH(8), .CONST_WIDTH(8), .CONST(0), .SIGNED(1'b0)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .a(a[7:0]),
    .out_valid(out_valid3), .out_ready(out_ready3), .mul(mul3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the shared handshake to the selected instance and pick its outputs.
  always_comb begin
    in_valid0 = in_valid && (sel == 0);
    in_valid1 = in_valid && (sel == 1);
    in_valid2 = in_valid && (sel == 2);
    in_valid3 = in_valid && (sel == 3);
    out_ready0 = out_ready && (sel == 0);
    out_ready1 = out_ready && (sel == 1);
    out_ready2 = out_ready && (sel == 2);
    out_ready3 = out_ready && (sel == 3);
    obs_in_ready  = in_ready0;
    obs_out_valid = out_valid0;
    obs_mul       = 32'(mul0);
    case (sel)
      1: begin obs_in_ready = in_ready1; obs_out_valid = out_valid1; obs_mul = 32'(mul1); end
      2: begin obs_in_ready = in_ready2; obs_out_valid = out_valid2; obs_mul = 32'(mul2); end
      3: begin obs_in_ready = in_ready3; obs_out_valid = out_valid3; obs_mul = 32'(mul3); end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full transaction: accept, measure latency, optional backpressure hold,
  // optional in_valid glitch during CALC, then release back to IDLE.
  task automatic applyStimulus(input int sel_i, input logic [11:0] a_i, input logic [31:0] exp_mul,
                               input int exp_lat, input int hold, input bit glitch, input string tag);
    int   cyc;
    int   waitCnt;
    bit   busyBad;
    bit   stableOk;
    logic [31:0] held;
    sel = sel_i;
    @(negedge clk);
    waitCnt = 0;
    while (!obs_in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "_ready_before"}, 32'(obs_in_ready), 32'd1);
    a = a_i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    busyBad = 1'b0;
    while (!obs_out_valid && cyc < 100) begin
      if (obs_in_ready) busyBad = 1'b1;
      if (glitch && cyc == 3) begin
        a = a_i ^ 12'h00C;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_busy_ready"}, 32'(busyBad), 32'd0);
    checkOutput({tag, "_mul"}, obs_mul, exp_mul);
    if (hold > 0) begin
      stableOk = 1'b1;
      held = obs_mul;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!obs_out_valid || obs_in_ready || obs_mul !== held) stableOk = 1'b0;
      end
      checkOutput({tag, "_hold_stable"}, 32'(stableOk), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_release_valid"}, 32'(obs_out_valid), 32'd0);
    checkOutput({tag, "_release_ready"}, 32'(obs_in_ready), 32'd1);
    checkOutput({tag, "_idle_mul"}, obs_mul, exp_mul);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] ra;
    checks = 0;
    errors = 0;
    sel = 0;
    a = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready0), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid0), 32'd0);
    checkOutput("reset_mul", 32'(mul0), 32'd0);
    rst = 1'b0;

    $display("[TB] default instance");
    applyStimulus(0, 12'h003, 32'h0033, 9, 0, 1'b0, "d_03");
    applyStimulus(0, 12'h0FF, 32'h10EF, 9, 0, 1'b0, "d_ff");
    applyStimulus(0, 12'h000, 32'h0000, 9, 0, 1'b0, "d_00");

    $display("[TB] signed instance");
    applyStimulus(1, 12'h080, 32'hF780, 9, 0, 1'b0, "s_80");
    applyStimulus(1, 12'h0FF, 32'hFFEF, 9, 0, 1'b0, "s_ff");
    applyStimulus(1, 12'h07F, 32'h086F, 9, 0, 1'b0, "s_7f");

    $display("[TB] backpressure and busy in_valid");
    applyStimulus(0, 12'h010, 32'h0110, 9, 20, 1'b0, "bp_10");
    applyStimulus(0, 12'h005, 32'h0055, 9, 0, 1'b1, "glitch_05");

    $display("[TB] reset during CALC");
    sel = 0;
    @(negedge clk);
    a = 12'h007;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid0), 32'd0);
    checkOutput("abort_mul", 32'(mul0), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 12'h002, 32'h0022, 9, 0, 1'b0, "after_abort");

    $display("[TB] CONST=0 instance");
    applyStimulus(3, 12'h0AB, 32'h0000, 9, 0, 1'b0, "c0_ab");

    $display("[TB] 12x5 sweep, CONST=31");
    applyStimulus(2, 12'hFFF, 32'h1EFE1, 6, 0, 1'b0, "w_fff");
    applyStimulus(2, 12'h001, 32'h0001F, 6, 0, 1'b0, "w_001");
    for (int k = 0; k < 6; k++) begin
      ra = 12'($urandom_range(0, 4095));
      applyStimulus(2, ra, 32'(ra) * 32'd31, 6, 0, 1'b0, "w_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
